// File: rtl/mod_sub_pipe_if.sv
// rtl/mod_sub_pipe_if.sv - operand/result handshake bundle for mod_sub_pipe
//
// Purpose: groups the input handshake (in_valid/in_ready with the a, b,
// modulant operands) and the output handshake (out_valid/out_ready with
// out, out_err) of the pipelined modular subtractor.
// Modports:
//   master - producer/consumer side: drives operands and out_ready
//   slave  - the subtractor: drives in_ready and the result side
interface mod_sub_pipe_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] modulant;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out;
  logic                  out_err;

  modport master (
    output in_valid, a, b, modulant, out_ready,
    input  in_ready, out_valid, out, out_err
  );

  modport slave (
    input  in_valid, a, b, modulant, out_ready,
    output in_ready, out_valid, out, out_err
  );
endinterface

// File: rtl/mod_sub_pipe.sv
// rtl/mod_sub_pipe.sv - two-stage pipelined (a - b) mod modulant
//
// Purpose: modular subtractor, inverse of the combinational modular adder.
// Stage 1 registers the widened difference, the modulus and a range-error
// flag; stage 2 folds a borrow back into range by adding the modulus.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mod_sub_pipe_if.slave: in_valid/in_ready/a/b/modulant in,
//           out_valid/out_ready/out/out_err out
module mod_sub_pipe #(
  parameter int DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mod_sub_pipe_if.slave bus
);

  logic                  s1_valid;
  logic [DATA_WIDTH:0]   s1_diff;
  logic [DATA_WIDTH-1:0] s1_mod;
  logic                  s1_err;

  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] out_q;
  logic                  err_q;

  logic                  s1_adv;
  logic                  s2_adv;
  logic [DATA_WIDTH:0]   in_diff;
  logic                  in_err;
  logic [DATA_WIDTH-1:0] s1_res;

  // A stage may advance when it is empty or its successor is draining,
  // so a full pipe keeps streaming as long as out_ready stays high.
  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // One extra bit so the MSB of the difference is the borrow.
  assign in_diff = {1'b0, bus.a} - {1'b0, bus.b};
  assign in_err  = (bus.a >= bus.modulant) || (bus.b >= bus.modulant) ||
                   (bus.modulant == '0);

  // With legal operands diff + modulant stays below 2^DATA_WIDTH, so the
  // truncating add only matters for out-of-range (err) inputs.
  assign s1_res = s1_diff[DATA_WIDTH] ? s1_diff[DATA_WIDTH-1:0] + s1_mod
                                      : s1_diff[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        out_q    <= s1_res;
        err_q    <= s1_err;
      end
    end
  end

  // Stage-1 payload is qualified by s1_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (s1_adv) begin
      s1_diff <= in_diff;
      s1_mod  <= bus.modulant;
      s1_err  <= in_err;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out       = out_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_mod_sub_pipe.sv
// tb/tb_mod_sub_pipe.sv - scoreboard bench for mod_sub_pipe
module tb_mod_sub_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_pops = 0;
  bit   accepted;
  logic [8:0] exp_q[$];
  int   pop_cyc[$];

  mod_sub_pipe_if #(.DATA_WIDTH(8)) bus ();

  mod_sub_pipe #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [8:0] model(int a, int b, int m);
    int d;
    logic e;
    d = a - b;
    if (d < 0) d = d + m;
    e = (a >= m) || (b >= m) || (m == 0);
    return {e, d[7:0]};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample handshakes at negedge, then advance one clock edge.
  task automatic tick();
    logic [8:0] e;
    @(negedge clk);
    accepted = 0;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out", {24'b0, bus.out}, {24'b0, e[7:0]});
        check("out_err", {31'b0, bus.out_err}, {31'b0, e[8]});
        pop_cyc.push_back(cyc);
        n_pops++;
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(int'(bus.a), int'(bus.b), int'(bus.modulant)));
      accepted = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(int a, int b, int m);
    int k;
    bus.in_valid = 1'b1;
    bus.a = a[7:0];
    bus.b = b[7:0];
    bus.modulant = m[7:0];
    k = 0;
    do begin
      tick();
      k++;
    end while (!accepted && k < 40);
    if (!accepted) check("send_timeout", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    int pops0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.modulant = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out", {24'b0, bus.out}, 32'd0);
    check("rst_out_err", {31'b0, bus.out_err}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single op latency and pulse width
    bus.out_ready = 1'b1;
    send(5, 3, 7);
    check("lat_edge0_valid", {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_edge1_valid", {31'b0, bus.out_valid}, 32'd1);
    check("lat_out", {24'b0, bus.out}, 32'd2);
    tick();
    check("lat_pulse_end", {31'b0, bus.out_valid}, 32'd0);

    // Back-to-back burst, wrap-around cases
    pop_cyc.delete();
    send(3, 5, 7);
    send(200, 200, 251);
    send(0, 250, 251);
    drain();
    check("burst_count", pop_cyc.size(), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("burst_gap0", pop_cyc[1] - pop_cyc[0], 32'd1);
      check("burst_gap1", pop_cyc[2] - pop_cyc[1], 32'd1);
    end

    // Backpressure
    pops0 = n_pops;
    bus.out_ready = 1'b0;
    send(1, 2, 13);
    send(12, 1, 13);
    check("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
    check("stall_out", {24'b0, bus.out}, 32'd12);
    bus.in_valid = 1'b1;
    bus.a = 8'd7;
    bus.b = 8'd7;
    bus.modulant = 8'd13;
    repeat (2) begin
      tick();
      check("stall_hold_accept", {31'b0, accepted}, 32'd0);
      check("stall_hold_out", {24'b0, bus.out}, 32'd12);
      check("stall_hold_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    send(7, 7, 13);
    send(0, 12, 13);
    drain();
    check("stall_results", n_pops - pops0, 32'd4);

    // Range errors
    send(9, 2, 7);
    send(0, 0, 0);
    send(3, 1, 7);
    drain();

    // Reset mid-operation
    bus.out_ready = 1'b0;
    send(1, 1, 5);
    send(2, 1, 5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mid_rst_out", {24'b0, bus.out}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst_idle", {31'b0, bus.out_valid}, 32'd0);
    end
    send(4, 6, 9);
    drain();
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
